// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the traffic sequencer and gate controller
package traffic_pkg;
    typedef enum logic [1:0] {RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10} traffic_t;
    typedef enum logic [1:0] {CLOSE = 2'b00, OPEN = 2'b01, WAIT = 2'b10} gate_t;
    typedef enum logic [1:0] {SEL_RED = 2'b00, SEL_GREEN = 2'b01, SEL_YELLOW = 2'b10} sel_t;
endpackage

// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: control inputs and phase outputs of the traffic sequencer
interface traffic_light_ctrl_if #(parameter int CNT_W = 8);
    logic             tick_en, cfg_we, req, emergency, phase_start, req_ack;
    logic [1:0]       cfg_sel, traffic_state;
    logic [CNT_W-1:0] cfg_data, remaining;
    modport master (
        output tick_en, cfg_we, cfg_sel, cfg_data, req, emergency,
        input  traffic_state, remaining, phase_start, req_ack
    );
    modport slave (
        input  tick_en, cfg_we, cfg_sel, cfg_data, req, emergency,
        output traffic_state, remaining, phase_start, req_ack
    );
endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// phase_timer: loadable down-counter; load beats hold, hold beats decrement
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    assign zero = count == '0;
    always_ff @(posedge clk) begin
        if (rst) count <= RST_VAL;
        else if (load) count <= load_val;
        else if (dec && !hold && !zero) count <= count - CNT_W'(1);
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: timed RED/GREEN/YELLOW sequencer with request shortening and emergency hold
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int RED_T     = 10,
    parameter int GREEN_T   = 15,
    parameter int YELLOW_T  = 3,
    parameter int REQ_GREEN = 5
) (
    input logic               clk,
    input logic               rst,
    traffic_light_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] REQ_M1 = CNT_W'(REQ_GREEN - 1);
    traffic_t         state, nxt;
    logic [CNT_W-1:0] dur_red, dur_green, dur_yellow, red_m1, green_m1, yellow_m1, load_val, count;
    logic             req_pend, emer_red_q, load, hold, zero, req_eff, red_entry, phase_start, req_ack;
    // a stored zero behaves as a one-tick phase
    assign red_m1    = dur_red    == '0 ? '0 : dur_red    - CNT_W'(1);
    assign green_m1  = dur_green  == '0 ? '0 : dur_green  - CNT_W'(1);
    assign yellow_m1 = dur_yellow == '0 ? '0 : dur_yellow - CNT_W'(1);
    assign req_eff   = req_pend | bus.req;
    assign red_entry = nxt == RED && nxt != state;
    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = red_m1;
        hold     = 1'b0;
        case (state)
            RED: begin
                hold = bus.emergency;
                if (!bus.emergency && emer_red_q) load = 1'b1;
                else if (!bus.emergency && bus.tick_en && zero) begin
                    nxt = GREEN; load = 1'b1; load_val = green_m1;
                end
            end
            GREEN: begin
                if (bus.emergency) begin
                    nxt = YELLOW; load = 1'b1; load_val = yellow_m1;
                end else if (req_eff && count > REQ_M1) begin
                    load = 1'b1; load_val = REQ_M1;
                end else if (bus.tick_en && zero) begin
                    nxt = YELLOW; load = 1'b1; load_val = yellow_m1;
                end
            end
            YELLOW: begin
                if (bus.tick_en && zero) begin
                    nxt = RED; load = 1'b1;
                end
            end
            default: begin
                nxt = RED; load = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RED;
            phase_start <= 1'b0;
            req_ack     <= 1'b0;
            req_pend    <= 1'b0;
            emer_red_q  <= 1'b0;
            dur_red     <= CNT_W'(RED_T);
            dur_green   <= CNT_W'(GREEN_T);
            dur_yellow  <= CNT_W'(YELLOW_T);
        end else begin
            state       <= nxt;
            phase_start <= nxt != state;
            req_ack     <= red_entry && req_pend;
            req_pend    <= bus.req || (req_pend && !red_entry);
            emer_red_q  <= state == RED && bus.emergency;
            if (bus.cfg_we && bus.cfg_sel == SEL_RED) dur_red <= bus.cfg_data;
            if (bus.cfg_we && bus.cfg_sel == SEL_GREEN) dur_green <= bus.cfg_data;
            if (bus.cfg_we && bus.cfg_sel == SEL_YELLOW) dur_yellow <= bus.cfg_data;
        end
    end
    phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(RED_T - 1))) u_timer (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .dec(bus.tick_en), .hold(hold), .count(count), .zero(zero)
    );
    assign bus.traffic_state = state;
    assign bus.remaining     = count;
    assign bus.phase_start   = phase_start;
    assign bus.req_ack       = req_ack;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed scenarios with hand-computed phase timelines
module tb_traffic_light_ctrl;
    import traffic_pkg::*;
    localparam int CNT_W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    traffic_light_ctrl_if #(.CNT_W(CNT_W)) bus ();
    traffic_light_ctrl #(
        .CNT_W(CNT_W), .RED_T(3), .GREEN_T(4), .YELLOW_T(2), .REQ_GREEN(2)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; bus.tick_en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0;
        bus.cfg_data = '0; bus.req = 1'b0; bus.emergency = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        rst = 1'b1; bus.tick_en = 1'b1; bus.emergency = 1'b1; bus.req = 1'b1;
        step(2);
        total++; if (bus.traffic_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.traffic_state); end
        total++; if (bus.remaining !== 8'd2) begin bad++; $display("FAIL reset_remaining got=%0d exp=2", bus.remaining); end
        total++; if (bus.phase_start !== 1'b0) begin bad++; $display("FAIL reset_phase_start got=%0b exp=0", bus.phase_start); end
        total++; if (bus.req_ack !== 1'b0) begin bad++; $display("FAIL reset_req_ack got=%0b exp=0", bus.req_ack); end
        rst = 1'b0; bus.tick_en = 1'b0; bus.emergency = 1'b0; bus.req = 1'b0;
    endtask

    task automatic test_free_run;
        logic [1:0] es [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        int         er [9] = '{1, 0, 3, 2, 1, 0, 1, 0, 2};
        logic       ep [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        bus.tick_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step(1);
            total++;
            if (bus.traffic_state !== es[k] || bus.remaining !== CNT_W'(er[k]) || bus.phase_start !== ep[k]) begin
                bad++;
                $display("FAIL free_run[%0d] got st=%0d rem=%0d ps=%0b exp st=%0d rem=%0d ps=%0b",
                         k + 1, bus.traffic_state, bus.remaining, bus.phase_start, es[k], er[k], ep[k]);
            end
        end
    endtask

    task automatic test_config;
        do_reset();
        bus.tick_en = 1'b1;
        step(3);
        bus.cfg_we = 1'b1; bus.cfg_sel = 2'd1; bus.cfg_data = 8'd6;
        step(1);
        bus.cfg_sel = 2'd2; bus.cfg_data = 8'd0;
        step(1);
        bus.cfg_we = 1'b0;
        step(2);
        total++; if ({bus.traffic_state, bus.remaining, bus.phase_start} !== {2'd2, 8'd0, 1'b1}) begin
            bad++; $display("FAIL cfg_yellow_entry got st=%0d rem=%0d ps=%0b exp st=2 rem=0 ps=1", bus.traffic_state, bus.remaining, bus.phase_start); end
        bus.cfg_we = 1'b1; bus.cfg_sel = 2'd3; bus.cfg_data = 8'd1;
        step(1);
        bus.cfg_we = 1'b0;
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd0, 8'd2}) begin
            bad++; $display("FAIL cfg_yellow_one_tick got st=%0d rem=%0d exp st=0 rem=2", bus.traffic_state, bus.remaining); end
        step(3);
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd1, 8'd5}) begin
            bad++; $display("FAIL cfg_new_green got st=%0d rem=%0d exp st=1 rem=5", bus.traffic_state, bus.remaining); end
        step(5);
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd1, 8'd0}) begin
            bad++; $display("FAIL cfg_green_last got st=%0d rem=%0d exp st=1 rem=0", bus.traffic_state, bus.remaining); end
        step(1);
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd2, 8'd0}) begin
            bad++; $display("FAIL cfg_yellow_again got st=%0d rem=%0d exp st=2 rem=0", bus.traffic_state, bus.remaining); end
        step(1);
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd0, 8'd2}) begin
            bad++; $display("FAIL cfg_sel3_ignored got st=%0d rem=%0d exp st=0 rem=2", bus.traffic_state, bus.remaining); end
    endtask

    task automatic test_request;
        do_reset();
        bus.tick_en = 1'b1;
        step(3);
        bus.req = 1'b1;
        step(1);
        bus.req = 1'b0;
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd1, 8'd1}) begin
            bad++; $display("FAIL req_truncate got st=%0d rem=%0d exp st=1 rem=1", bus.traffic_state, bus.remaining); end
        step(2);
        total++; if ({bus.traffic_state, bus.remaining, bus.req_ack} !== {2'd2, 8'd1, 1'b0}) begin
            bad++; $display("FAIL req_yellow got st=%0d rem=%0d ack=%0b exp st=2 rem=1 ack=0", bus.traffic_state, bus.remaining, bus.req_ack); end
        step(2);
        total++; if ({bus.traffic_state, bus.phase_start, bus.req_ack} !== {2'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL req_ack_at_red got st=%0d ps=%0b ack=%0b exp st=0 ps=1 ack=1", bus.traffic_state, bus.phase_start, bus.req_ack); end
        step(1);
        total++; if (bus.req_ack !== 1'b0) begin bad++; $display("FAIL req_ack_single got=%0b exp=0", bus.req_ack); end
        step(3);
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd1, 8'd2}) begin
            bad++; $display("FAIL req_cleared got st=%0d rem=%0d exp st=1 rem=2", bus.traffic_state, bus.remaining); end
    endtask

    task automatic test_emergency;
        do_reset();
        bus.tick_en = 1'b1;
        step(4);
        bus.tick_en = 1'b0; bus.emergency = 1'b1;
        step(1);
        total++; if ({bus.traffic_state, bus.remaining, bus.phase_start} !== {2'd2, 8'd1, 1'b1}) begin
            bad++; $display("FAIL emg_to_yellow got st=%0d rem=%0d ps=%0b exp st=2 rem=1 ps=1", bus.traffic_state, bus.remaining, bus.phase_start); end
        bus.tick_en = 1'b1;
        step(2);
        total++; if ({bus.traffic_state, bus.remaining, bus.phase_start} !== {2'd0, 8'd2, 1'b1}) begin
            bad++; $display("FAIL emg_to_red got st=%0d rem=%0d ps=%0b exp st=0 rem=2 ps=1", bus.traffic_state, bus.remaining, bus.phase_start); end
        for (int k = 0; k < 20; k++) begin
            step(1);
            total++; if ({bus.traffic_state, bus.remaining, bus.phase_start} !== {2'd0, 8'd2, 1'b0}) begin
                bad++; $display("FAIL emg_hold[%0d] got st=%0d rem=%0d ps=%0b exp st=0 rem=2 ps=0", k, bus.traffic_state, bus.remaining, bus.phase_start); end
        end
        bus.emergency = 1'b0;
        step(2);
        bus.emergency = 1'b1;
        step(5);
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd0, 8'd1}) begin
            bad++; $display("FAIL emg_freeze_mid got st=%0d rem=%0d exp st=0 rem=1", bus.traffic_state, bus.remaining); end
        bus.emergency = 1'b0;
        step(1);
        total++; if ({bus.traffic_state, bus.remaining, bus.phase_start} !== {2'd0, 8'd2, 1'b0}) begin
            bad++; $display("FAIL emg_release_reload got st=%0d rem=%0d ps=%0b exp st=0 rem=2 ps=0", bus.traffic_state, bus.remaining, bus.phase_start); end
        step(3);
        total++; if ({bus.traffic_state, bus.remaining, bus.phase_start} !== {2'd1, 8'd3, 1'b1}) begin
            bad++; $display("FAIL emg_resume_green got st=%0d rem=%0d ps=%0b exp st=1 rem=3 ps=1", bus.traffic_state, bus.remaining, bus.phase_start); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        bus.tick_en = 1'b1;
        step(6);
        bus.emergency = 1'b1; bus.req = 1'b1;
        step(1);
        bus.emergency = 1'b0; bus.req = 1'b0;
        total++; if ({bus.traffic_state, bus.remaining, bus.req_ack} !== {2'd2, 8'd1, 1'b0}) begin
            bad++; $display("FAIL sim_yellow got st=%0d rem=%0d ack=%0b exp st=2 rem=1 ack=0", bus.traffic_state, bus.remaining, bus.req_ack); end
        step(2);
        total++; if ({bus.traffic_state, bus.phase_start, bus.req_ack} !== {2'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL sim_red_ack got st=%0d ps=%0b ack=%0b exp st=0 ps=1 ack=1", bus.traffic_state, bus.phase_start, bus.req_ack); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.tick_en = 1'b1; bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_data = 8'd5;
        step(1);
        bus.cfg_we = 1'b0;
        step(2);
        bus.req = 1'b1;
        step(1);
        bus.req = 1'b0;
        step(2);
        total++; if (bus.traffic_state !== 2'd2) begin bad++; $display("FAIL rstmid_in_yellow got st=%0d exp st=2", bus.traffic_state); end
        rst = 1'b1; bus.emergency = 1'b1; bus.req = 1'b1;
        step(1);
        total++; if ({bus.traffic_state, bus.remaining, bus.phase_start, bus.req_ack} !== {2'd0, 8'd2, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rstmid_red got st=%0d rem=%0d ps=%0b ack=%0b exp st=0 rem=2 ps=0 ack=0", bus.traffic_state, bus.remaining, bus.phase_start, bus.req_ack); end
        rst = 1'b0; bus.emergency = 1'b0; bus.req = 1'b0;
        step(3);
        total++; if ({bus.traffic_state, bus.remaining, bus.phase_start} !== {2'd1, 8'd3, 1'b1}) begin
            bad++; $display("FAIL rstmid_green got st=%0d rem=%0d ps=%0b exp st=1 rem=3 ps=1", bus.traffic_state, bus.remaining, bus.phase_start); end
        step(4);
        total++; if ({bus.traffic_state, bus.remaining} !== {2'd2, 8'd1}) begin
            bad++; $display("FAIL rstmid_yellow got st=%0d rem=%0d exp st=2 rem=1", bus.traffic_state, bus.remaining); end
        step(2);
        total++; if ({bus.traffic_state, bus.remaining, bus.req_ack} !== {2'd0, 8'd2, 1'b0}) begin
            bad++; $display("FAIL rstmid_red_dur got st=%0d rem=%0d ack=%0b exp st=0 rem=2 ack=0", bus.traffic_state, bus.remaining, bus.req_ack); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_free_run();
        test_config();
        test_request();
        test_emergency();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
